// File: rtl/mem_io_responder.sv
// mem_io_responder: processor-side bus responder decoding RAM, LEDs, switches and a down-counting timer
module mem_io_responder #(
  parameter int MEM_AW   = 7,
  parameter int N_LED    = 10,
  parameter int N_SW     = 10,
  parameter int PRESCALE = 50000,
  parameter int PS_W     = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       DOUT,
  input  logic              W,
  output logic [15:0]       DIN,
  input  logic [N_SW-1:0]   SW,
  output logic [N_LED-1:0]  LEDR,
  output logic              Tick_flag
);
  logic [15:0] mem [2**MEM_AW];
  logic [15:0] din_q, din_d, cnt_q, cnt_d, rld_q, rld_d;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_SW-1:0] sw1_q, sw2_q;
  logic [PS_W-1:0] ps_q, ps_d;
  logic en_q, en_d, ar_q, ar_d, flag_q, flag_d;
  logic sel_ram, sel_led, sel_sw, sel_tmr, wr_cnt, wr_ctl, run, tick, unused_addr;
  logic [MEM_AW-1:0] idx;
  assign idx         = ADDR[MEM_AW-1:0];
  assign sel_ram     = ADDR[15:12] == 4'h0;
  assign sel_led     = ADDR[15:12] == 4'h1;
  assign sel_sw      = ADDR[15:12] == 4'h2;
  assign sel_tmr     = ADDR[15:12] == 4'h3;
  assign wr_cnt      = W && sel_tmr && !ADDR[0];
  assign wr_ctl      = W && sel_tmr && ADDR[0];
  assign run         = en_q && cnt_q != '0;
  assign tick        = run && ps_q == PS_W'(PRESCALE - 1);
  assign unused_addr = ^ADDR[11:MEM_AW];
  // Read data is taken from next-state values so same-cycle writes are visible (write-first)
  always_comb begin
    led_d  = W && sel_led ? DOUT[N_LED-1:0] : led_q;
    ps_d   = (wr_cnt || tick || !run) ? '0 : ps_q + PS_W'(1);
    cnt_d  = wr_cnt ? DOUT : !tick ? cnt_q : cnt_q == 16'd1 ? (ar_q ? rld_q : '0) : cnt_q - 16'd1;
    rld_d  = wr_cnt ? DOUT : rld_q;
    en_d   = wr_ctl ? DOUT[0] : en_q;
    ar_d   = wr_ctl ? DOUT[1] : ar_q;
    flag_d = (tick && cnt_q == 16'd1) || (flag_q && !(wr_ctl && DOUT[2]));
    din_d  = sel_ram ? (W ? DOUT : mem[idx]) :
             sel_led ? 16'(led_d) :
             sel_sw  ? 16'(sw2_q) :
             sel_tmr ? (ADDR[0] ? {13'b0, flag_d, ar_d, en_d} : cnt_d) : '0;
  end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      din_q  <= '0;
      led_q  <= '0;
      sw1_q  <= '0;
      sw2_q  <= '0;
      cnt_q  <= '0;
      rld_q  <= '0;
      ps_q   <= '0;
      en_q   <= 1'b0;
      ar_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      din_q  <= din_d;
      led_q  <= led_d;
      sw1_q  <= SW;
      sw2_q  <= sw1_q;
      cnt_q  <= cnt_d;
      rld_q  <= rld_d;
      ps_q   <= ps_d;
      en_q   <= en_d;
      ar_q   <= ar_d;
      flag_q <= flag_d;
    end
  always_ff @(posedge Clock)
    if (W && sel_ram) mem[idx] <= DOUT;
  assign DIN       = din_q;
  assign LEDR      = led_q;
  assign Tick_flag = flag_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed plus random bus traffic checked against a behavioural model
module tb_mem_io_responder;
  localparam int P = 4;
  logic clk = 0, rst_n = 1, w = 0, tf;
  logic [15:0] a = 0, d = 0, din;
  logic [9:0] sw = 0, ledr;
  int total = 0, bad = 0;
  logic [15:0] m_mem [128];
  bit m_val [128];
  logic [15:0] m_din, m_cnt, m_rld;
  logic [9:0] m_led, m_s1, m_s2;
  logic m_en, m_ar, m_flag;
  int m_ps;
  bit din_known;
  mem_io_responder #(.MEM_AW(7), .N_LED(10), .N_SW(10), .PRESCALE(P), .PS_W(16)) dut (
    .Clock(clk), .Resetn(rst_n), .ADDR(a), .DOUT(d), .W(w), .DIN(din), .SW(sw), .LEDR(ledr), .Tick_flag(tf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_din = 0; m_cnt = 0; m_rld = 0; m_led = 0; m_s1 = 0; m_s2 = 0;
    m_en = 0; m_ar = 0; m_flag = 0; m_ps = 0; din_known = 1;
  endtask
  // One rising edge of the spec: timer advance from old state, then bus writes, then the write-first read
  task automatic model_edge();
    logic [9:0] old_s2;
    bit expd;
    int r;
    old_s2 = m_s2;
    expd = 0;
    r = int'(a[15:12]);
    m_s2 = m_s1;
    m_s1 = sw;
    if (m_en && m_cnt != 0) begin
      if (m_ps == P - 1) begin
        m_ps = 0;
        if (m_cnt == 1) begin
          expd = 1;
          m_cnt = m_ar ? m_rld : 16'h0;
        end else m_cnt = m_cnt - 1;
      end else m_ps++;
    end else m_ps = 0;
    if (w)
      case (r)
        0: begin m_mem[a[6:0]] = d; m_val[a[6:0]] = 1; end
        1: m_led = d[9:0];
        3: if (!a[0]) begin m_rld = d; m_cnt = d; m_ps = 0; end
           else begin m_en = d[0]; m_ar = d[1]; if (d[2]) m_flag = 0; end
        default: ;
      endcase
    if (expd) m_flag = 1;
    din_known = 1;
    case (r)
      0: begin din_known = m_val[a[6:0]]; m_din = m_mem[a[6:0]]; end
      1: m_din = 16'(m_led);
      2: m_din = 16'(old_s2);
      3: m_din = a[0] ? {13'b0, m_flag, m_ar, m_en} : m_cnt;
      default: m_din = 0;
    endcase
  endtask
  task automatic cyc(input logic [15:0] ad, input logic [15:0] dd, input logic wr);
    a = ad; d = dd; w = wr;
    @(posedge clk);
    model_edge();
    #1;
    if (din_known) chk("din", din, m_din);
    chk("ledr", 16'(ledr), 16'(m_led));
    chk("flag", {15'b0, tf}, {15'b0, m_flag});
  endtask
  initial begin
    model_reset();
    #2 rst_n = 0;
    #10;
    chk("rst_din", din, 16'h0);
    chk("rst_led", 16'(ledr), 16'h0);
    chk("rst_flag", {15'b0, tf}, 16'h0);
    @(negedge clk) rst_n = 1;
    cyc(16'h1000, 0, 0);
    chk("idle_din", din, 16'h0);
    cyc(16'h0005, 16'hBEEF, 1);
    cyc(16'h0005, 0, 0);
    chk("ram_rd", din, 16'hBEEF);
    cyc(16'h0085, 0, 0);
    chk("ram_alias", din, 16'hBEEF);
    cyc(16'h1000, 16'hFFFF, 1);
    chk("led_wr", 16'(ledr), 16'h03FF);
    cyc(16'h1000, 0, 0);
    chk("led_rd", din, 16'h03FF);
    sw = 10'h155;
    repeat (3) cyc(16'h2000, 0, 0);
    chk("sw_rd", din, 16'h0155);
    cyc(16'h2000, 16'h1234, 1);
    chk("sw_wr_ign", din, 16'h0155);
    cyc(16'h3000, 16'd3, 1);
    cyc(16'h3001, 16'h0001, 1);
    repeat (4) cyc(16'h3000, 0, 0);
    chk("tmr_2", din, 16'd2);
    repeat (4) cyc(16'h3000, 0, 0);
    chk("tmr_1", din, 16'd1);
    repeat (3) cyc(16'h3000, 0, 0);
    chk("tmr_pre_flag", {15'b0, tf}, 16'h0);
    cyc(16'h3000, 0, 0);
    chk("tmr_0", din, 16'd0);
    chk("tmr_flag", {15'b0, tf}, 16'h1);
    repeat (5) cyc(16'h3000, 0, 0);
    chk("tmr_hold0", din, 16'd0);
    cyc(16'h3001, 0, 0);
    chk("stat_5", din, 16'h0005);
    cyc(16'h3001, 16'h0005, 1);
    cyc(16'h3001, 0, 0);
    chk("stat_clr", din, 16'h0001);
    cyc(16'h3001, 16'h0003, 1);
    cyc(16'h3000, 16'd2, 1);
    repeat (7) cyc(16'h3000, 0, 0);
    cyc(16'h3001, 16'h0007, 1);
    chk("set_wins", {15'b0, tf}, 16'h1);
    chk("stat_7", din, 16'h0007);
    cyc(16'h3000, 0, 0);
    chk("reload", din, 16'd2);
    repeat (2) cyc(16'h3000, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_din", din, 16'h0);
    chk("midrst_led", 16'(ledr), 16'h0);
    chk("midrst_flag", {15'b0, tf}, 16'h0);
    model_reset();
    @(negedge clk) rst_n = 1;
    cyc(16'h3000, 0, 0);
    chk("midrst_cnt", din, 16'h0);
    cyc(16'h3001, 0, 0);
    chk("midrst_stat", din, 16'h0);
    cyc(16'h1000, 16'h0155, 1);
    cyc(16'h7000, 0, 0);
    chk("unmap_rd", din, 16'h0);
    cyc(16'h7000, 16'hFFFF, 1);
    chk("unmap_led", 16'(ledr), 16'h0155);
    cyc(16'h0005, 0, 0);
    chk("unmap_ram", din, 16'hBEEF);
    cyc(16'h3001, 0, 0);
    chk("unmap_tmr", din, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rg;
      logic [15:0] ad, dd;
      int k;
      k = $urandom_range(0, 9);
      rg = k < 3 ? 4'h0 : k < 5 ? 4'h1 : k == 5 ? 4'h2 : k < 8 ? 4'h3 : 4'($urandom_range(4, 15));
      ad = {rg, 12'($urandom)};
      dd = rg == 4'h3 ? 16'($urandom_range(0, 7)) : 16'($urandom);
      if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
      cyc(ad, dd, $urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Bus responder on the processor side of the memory interface. The processor drives ADDR, DOUT and W; this block returns read data on DIN.
- Decodes ADDR[15:12] into four regions: word RAM, LED output register, synchronized switch input, and a down-counting timer with a sticky expiry flag.
- Sits beside the processor at the top level and is the only source of the processor's DIN.

Parameters:
- MEM_AW, 7, RAM address width (2^MEM_AW 16-bit words, indexed by ADDR[MEM_AW-1:0]).
- N_LED, 10, width of LED register.
- N_SW, 10, width of switch input.
- PRESCALE, 50000, clock cycles per timer tick (>=1).
- PS_W, 16, prescaler counter width (must hold PRESCALE-1).

Ports:
- Clock  in  1  system clock, rising-edge.
- Resetn  in  1  asynchronous active-low reset.
- ADDR  in  16  word address from the processor.
- DOUT  in  16  write data from the processor.
- W  in  1  write strobe. Qualifies ADDR/DOUT in the same cycle.
- DIN  out  16  registered read data to the processor.
- SW  in  N_SW  asynchronous switch inputs.
- LEDR  out  N_LED  LED register.
- Tick_flag  out  1  timer expiry flag (same as status bit2).

Behaviour:
- Reset (async, Resetn=0): DIN=0, LEDR=0, timer count=0, enable=0, autoreload=0, flag=0, prescaler=0, reload=0, SW sync flops=0. RAM contents are not reset.
- Region decode on ADDR[15:12]:
  - 0 = RAM.
  - 1 = LED register.
  - 2 = switch input.
  - 3 = timer. ADDR[0] selects timer offset: 0 = count, 1 = control/status.
  - 4..F = unmapped: read 0, writes ignored.
  - Bits between ADDR[11:MEM_AW] (RAM) and ADDR[11:1] (timer) are ignored (aliasing).
- Writes occur at the rising edge where W=1:
  - RAM: mem[ADDR[MEM_AW-1:0]] <= DOUT.
  - LED: LEDR <= DOUT[N_LED-1:0].
  - Switch region: read-only, write ignored.
  - Timer offset 0: reload <= DOUT; count <= DOUT; prescaler <= 0.
  - Timer offset 1: enable <= DOUT[0]; autoreload <= DOUT[1]. If DOUT[2]=1, clear flag.
- Read latency is 1 cycle: every edge DIN <= selected data for the current ADDR, regardless of W. Reads have no side effects.
  - Write-first: if W=1 to the same location in cycle n, DIN after edge n shows the new value (LED, RAM and timer alike).
  - Read data by region:
    - LED: DIN = zero-extended LEDR.
    - Switch: DIN = zero-extended 2-flop-synchronized SW.
    - Timer offset 0: DIN = count.
    - Timer offset 1: DIN = {13'b0, flag, autoreload, enable}.
- Timer, when enable=1 and count!=0:
  - Prescaler increments each cycle. At PRESCALE-1 it wraps to 0 and count decrements by 1 (one tick).
  - When a tick takes count from 1 to 0: flag <= 1. If autoreload=1, count <= reload (reload=0 means the timer stays at 0); otherwise count holds 0 and ticks stop.
- Timer, when enable=0 or count==0: prescaler holds at 0, count holds.
- Simultaneous events:
  - Expiry and a flag-clear write in the same cycle: set wins, flag=1.
  - Count write and tick in the same cycle: write wins; count=DOUT, prescaler=0.
  - Control write enabling the timer takes effect the next cycle.
- Reset asserted mid-count or mid-write: all registers go to reset values immediately. A RAM write in that cycle is not guaranteed.

Test Plan:
- Reset, then idle with ADDR=0x1000 -> LEDR=0, DIN=0, Tick_flag=0.
- RAM write/read: W=1, ADDR=0x0005, DOUT=0xBEEF; next cycle W=0, same ADDR -> DIN=0xBEEF one edge later. Then ADDR=0x0085 (alias when MEM_AW=7) -> DIN=0xBEEF.
- LED write with DOUT=0xFFFF -> LEDR=0x3FF; read of 0x1000 -> DIN=0x03FF.
- Switch read: set SW=0x155 asynchronously, ADDR=0x2000 -> DIN=0x0155 no later than 3 edges after SW changes. Then write 0x1234 to 0x2000 -> ignored, DIN still 0x0155.
- Timer with PRESCALE=4: write count=3 to 0x3000, then control=0x0001.
  - Count reads 2, 1, 0 at 4-cycle intervals.
  - Tick_flag rises on the edge count reaches 0, and count stays 0.
  - Status reads 0x0005.
  - Write control=0x0005 -> flag clears, status reads 0x0001.
- Autoreload plus set-wins: control=0x0003, count=2.
  - Flag sets at expiry and count reloads to 2.
  - A clear write (0x0007) placed exactly on the expiry edge leaves Tick_flag=1.
  - Assert Resetn=0 mid-count -> count=0, enable=0, flag=0 immediately.
- Unmapped read: ADDR=0x7000 -> DIN=0. W=1 with DOUT=0xFFFF to 0x7000 -> no change to LEDR, RAM or timer.
